// File: rtl/hash_target_rx.sv
// hash_target_rx: UART 8N1 receiver and frame parser that loads a 128-bit
// MD5 target hash from the host. A frame is SYNC_BYTE, 16 hash bytes and
// an XOR checksum byte. The hash is presented MSB-first as target[0:127],
// with frame byte 0 in target[0:7].
module hash_target_rx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'h48,
    parameter int          TIMEOUT_BITS = 40
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx,
    output logic         rx_led,
    output logic [0:127] target,
    output logic         target_valid,
    output logic         target_loaded,
    output logic         frame_error
);

    // The bit timer only has to reach CLKS_PER_BIT-1. The idle counter has
    // to hold the full timeout length without wrapping.
    localparam int HALF_BIT      = CLKS_PER_BIT / 2;
    localparam int TIMER_W       = $clog2(CLKS_PER_BIT);
    localparam int TIMEOUT_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int IDLE_W        = $clog2(TIMEOUT_LIMIT + 1);

    localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(HALF_BIT - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(TIMEOUT_LIMIT - 1);
    localparam logic [IDLE_W-1:0]  IDLE_ONE  = IDLE_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } bitState_t;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        LOAD,
        CHECK
    } frameState_t;

    // Input synchroniser
    logic r_rxMeta;
    logic r_rxSync;

    // Bit-level receiver
    bitState_t          r_bitState;
    bitState_t          w_bitNext;
    logic [TIMER_W-1:0] r_bitTimer;
    logic [2:0]         r_bitCount;
    logic [7:0]         r_shift;
    logic               w_tick;
    logic               w_byteStrobe;
    logic               w_stopErr;

    // Frame-level parser
    frameState_t        r_frameState;
    frameState_t        w_frameNext;
    logic [3:0]         r_idx;
    logic [7:0]         r_csum;
    logic [0:127]       r_buffer;
    logic [IDLE_W-1:0]  r_idleCnt;
    logic               w_idleRun;
    logic               w_timeout;
    logic               w_csumOk;
    logic               w_isSync;
    logic               w_startFrame;
    logic               w_storeByte;
    logic               w_loadTarget;
    logic               w_csumErr;
    logic               w_frameErr;

    // Two-flop synchroniser for the asynchronous rx pin. Both flops reset
    // to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
        end
    end

    // Bit FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bitState <= IDLE;
        end else begin
            r_bitState <= w_bitNext;
        end
    end

    // Bit FSM next state. START is checked at mid-bit so a short low
    // glitch returns to IDLE quietly. A low stop bit parks the receiver in
    // BREAK until the line goes high again, so a held-low line cannot
    // produce further bytes.
    always_comb begin
        w_bitNext = r_bitState;
        case (r_bitState)
            IDLE: begin
                if (!r_rxSync) begin
                    w_bitNext = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_bitNext = r_rxSync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_tick && (r_bitCount == 3'd7)) begin
                    w_bitNext = STOP;
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_bitNext = r_rxSync ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (r_rxSync) begin
                    w_bitNext = IDLE;
                end
            end
            default: begin
                w_bitNext = IDLE;
            end
        endcase
    end

    // Bit FSM outputs: the sample tick for the current state, and the
    // byte-complete / stop-error events raised in the stop-bit sample cycle.
    always_comb begin
        w_tick       = 1'b0;
        w_byteStrobe = 1'b0;
        w_stopErr    = 1'b0;
        case (r_bitState)
            START:       w_tick = (r_bitTimer == HALF_LAST);
            DATA, STOP:  w_tick = (r_bitTimer == BIT_LAST);
            default:     w_tick = 1'b0;
        endcase
        if ((r_bitState == STOP) && w_tick) begin
            w_byteStrobe = r_rxSync;
            w_stopErr    = !r_rxSync;
        end
    end

    // Bit timer, bit counter and LSB-first shift register. The timer
    // restarts on every sample tick so each data sample lands one full bit
    // period after the mid-start-bit sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bitTimer <= '0;
            r_bitCount <= '0;
            r_shift    <= '0;
        end else begin
            case (r_bitState)
                START, STOP: begin
                    r_bitTimer <= w_tick ? '0 : (r_bitTimer + TIMER_ONE);
                end
                DATA: begin
                    if (w_tick) begin
                        r_bitTimer <= '0;
                        r_bitCount <= r_bitCount + 3'd1;
                        r_shift    <= {r_rxSync, r_shift[7:1]};
                    end else begin
                        r_bitTimer <= r_bitTimer + TIMER_ONE;
                    end
                end
                default: begin
                    r_bitTimer <= '0;
                    r_bitCount <= '0;
                end
            endcase
        end
    end

    // Frame-side helper terms. The idle counter only runs while a frame is
    // open and the line is between bytes.
    assign w_idleRun = (r_frameState != WAIT_SYNC) && (r_bitState == IDLE);
    assign w_timeout = w_idleRun && (r_idleCnt == IDLE_LAST);
    assign w_csumOk  = (r_shift == r_csum);
    assign w_isSync  = (r_shift == SYNC_BYTE);

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frameState <= WAIT_SYNC;
        end else begin
            r_frameState <= w_frameNext;
        end
    end

    // Frame FSM next state. Stop-bit errors and timeouts abandon the frame
    // and take priority over any byte progress. Inside LOAD a sync byte is
    // just data; there is no resynchronisation.
    always_comb begin
        w_frameNext = r_frameState;
        if (w_stopErr || w_timeout) begin
            w_frameNext = WAIT_SYNC;
        end else if (w_byteStrobe) begin
            case (r_frameState)
                WAIT_SYNC: begin
                    if (w_isSync) begin
                        w_frameNext = LOAD;
                    end
                end
                LOAD: begin
                    if (r_idx == 4'd15) begin
                        w_frameNext = CHECK;
                    end
                end
                CHECK: begin
                    w_frameNext = WAIT_SYNC;
                end
                default: begin
                    w_frameNext = WAIT_SYNC;
                end
            endcase
        end
    end

    // Frame FSM outputs: per-cycle actions on the buffer and target, plus
    // the activity LED. Exactly one failure source can be active in any
    // cycle, so OR-ing them gives one error pulse per event.
    always_comb begin
        rx_led       = (r_frameState != WAIT_SYNC);
        w_startFrame = 1'b0;
        w_storeByte  = 1'b0;
        w_loadTarget = 1'b0;
        w_csumErr    = 1'b0;
        if (w_byteStrobe && !w_stopErr && !w_timeout) begin
            case (r_frameState)
                WAIT_SYNC: w_startFrame = w_isSync;
                LOAD:      w_storeByte  = 1'b1;
                CHECK: begin
                    w_loadTarget = w_csumOk;
                    w_csumErr    = !w_csumOk;
                end
                default: begin
                    w_startFrame = 1'b0;
                end
            endcase
        end
        w_frameErr = w_stopErr || w_timeout || w_csumErr;
    end

    // Frame buffer, byte index and running checksum. Byte idx lands in
    // r_buffer[idx*8 +: 8], which keeps byte 0 at the MSB end.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buffer <= '0;
            r_idx    <= '0;
            r_csum   <= '0;
        end else if (w_startFrame) begin
            r_idx  <= '0;
            r_csum <= '0;
        end else if (w_storeByte) begin
            r_buffer[{r_idx, 3'b000} +: 8] <= r_shift;
            r_csum                         <= r_csum ^ r_shift;
            r_idx                          <= r_idx + 4'd1;
        end
    end

    // Inter-byte idle counter. It is cleared whenever a byte is in flight,
    // on every completed byte, outside a frame, and when it expires.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idleCnt <= '0;
        end else if (!w_idleRun || w_byteStrobe || w_timeout) begin
            r_idleCnt <= '0;
        end else begin
            r_idleCnt <= r_idleCnt + IDLE_ONE;
        end
    end

    // Registered outputs. target only changes on a frame whose checksum
    // matches, so failed frames leave the previous hash in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            target        <= '0;
            target_valid  <= 1'b0;
            target_loaded <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            target_valid <= w_loadTarget;
            frame_error  <= w_frameErr;
            if (w_loadTarget) begin
                target        <= r_buffer;
                target_loaded <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hash_target_rx.sv
// tb_hash_target_rx: drives framed hashes into hash_target_rx over a bit-
// banged UART line and compares every target_valid / frame_error event
// against a byte-stream reference model.
module tb_hash_target_rx;

    localparam int         C          = 16;
    localparam int         HALF       = C / 2;
    localparam int         TOB        = 40;
    localparam int         LIMIT      = TOB * C;
    localparam logic [7:0] SYNC       = 8'h48;
    // Edge (counted from the start-bit edge) after which an event caused by
    // the stop-bit sample becomes visible: 2 synchroniser flops, 1 cycle to
    // leave IDLE, half a bit, nine full bits, then the output register.
    localparam int         STROBE_OFS = 3 + HALF + 9 * C;

    logic         clk = 1'b0;
    logic         reset;
    logic         rx;
    logic         rx_led;
    logic [0:127] target;
    logic         target_valid;
    logic         target_loaded;
    logic         frame_error;

    typedef struct packed {
        logic         isErr;
        logic [127:0] tgt;
        int           cycle;
        int           tol;
    } expect_t;

    expect_t      expQ[$];
    expect_t      monEntry;
    int           nTests = 0;
    int           nFail  = 0;
    int           cyc    = 0;

    // Reference model state: are we inside a frame, which bytes arrived,
    // what hash should currently be held.
    logic         mInFrame;
    logic [7:0]   mBytes[$];
    logic [127:0] mTarget;
    int           mLastStrobe;

    hash_target_rx #(
        .CLKS_PER_BIT (C),
        .SYNC_BYTE    (SYNC),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx            (rx),
        .rx_led        (rx_led),
        .target        (target),
        .target_valid  (target_valid),
        .target_loaded (target_loaded),
        .frame_error   (frame_error)
    );

    // Free-running clock and a cycle counter used to time events.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        nTests++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushEvent(input logic isErr, input logic [127:0] tgt,
                             input int cycle, input int tol);
        expect_t e;
        e.isErr = isErr;
        e.tgt   = tgt;
        e.cycle = cycle;
        e.tol   = tol;
        expQ.push_back(e);
    endtask

    // Feed one correctly framed byte into the model. A frame is the sync
    // byte, 16 data bytes and a checksum equal to the XOR of the data.
    task automatic modelByte(input logic [7:0] b, input int strobeCyc);
        logic [7:0]   x;
        logic [127:0] img;
        mLastStrobe = strobeCyc;
        if (!mInFrame) begin
            if (b == SYNC) begin
                mInFrame = 1'b1;
                mBytes.delete();
            end
        end else begin
            mBytes.push_back(b);
            if (mBytes.size() == 17) begin
                x   = 8'h00;
                img = '0;
                for (int i = 0; i < 16; i++) begin
                    x   = x ^ mBytes[i];
                    img = {img[119:0], mBytes[i]};
                end
                if (mBytes[16] == x) begin
                    mTarget = img;
                    pushEvent(1'b0, img, strobeCyc, 0);
                end else begin
                    pushEvent(1'b1, mTarget, strobeCyc, 0);
                end
                mInFrame = 1'b0;
            end
        end
    endtask

    // Send one UART byte, LSB first, with a chosen stop-bit level. The
    // expected outcome is registered before the line is driven.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        int t0;
        @(posedge clk);
        #1;
        t0 = cyc;
        if (stopBit) begin
            modelByte(data, t0 + STROBE_OFS);
        end else begin
            pushEvent(1'b1, mTarget, t0 + STROBE_OFS, 0);
            mInFrame = 1'b0;
        end
        rx = 1'b0;
        repeat (C) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = data[i];
            repeat (C) @(posedge clk);
        end
        #1 rx = stopBit;
        repeat (C) @(posedge clk);
        #1;
    endtask

    // Idle line for n cycles; a long enough gap inside a frame times out.
    task automatic applyIdle(input int n);
        if (mInFrame && (n > LIMIT + 5)) begin
            pushEvent(1'b1, mTarget, mLastStrobe + LIMIT, 1);
            mInFrame = 1'b0;
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input logic [127:0] img, input logic [7:0] csumXor);
        logic [7:0] cs;
        cs = 8'h00;
        applyStimulus(SYNC, 1'b1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(img[127 - 8 * i -: 8], 1'b1);
            cs = cs ^ img[127 - 8 * i -: 8];
        end
        applyStimulus(cs ^ csumXor, 1'b1);
    endtask

    function automatic logic [127:0] randImg();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_target"}, target, '0);
        checkOutput({tag, "_valid"}, target_valid, 0);
        checkOutput({tag, "_loaded"}, target_loaded, 0);
        checkOutput({tag, "_error"}, frame_error, 0);
        checkOutput({tag, "_led"}, rx_led, 0);
    endtask

    // Whenever the DUT reports an event, take the oldest expected event and
    // compare kind, hash, loaded flag and timing.
    always @(negedge clk) begin
        if (!reset && (target_valid || frame_error)) begin
            if (expQ.size() == 0) begin
                nTests++;
                nFail++;
                $display("[TB] FAIL unexpectedEvent: got valid=%0b error=%0b at cycle %0d expected no event",
                         target_valid, frame_error, cyc);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("eventKind", {target_valid, frame_error},
                            monEntry.isErr ? 2'b01 : 2'b10);
                checkOutput("eventTarget", target, monEntry.tgt);
                if (!monEntry.isErr) begin
                    checkOutput("loadedOnValid", target_loaded, 1);
                end
                nTests++;
                if ((cyc < monEntry.cycle - monEntry.tol) ||
                    (cyc > monEntry.cycle + monEntry.tol)) begin
                    nFail++;
                    $display("[TB] FAIL eventCycle: got cycle %0d expected %0d +/- %0d",
                             cyc, monEntry.cycle, monEntry.tol);
                end
            end
        end
    end

    // Hard stop if the run ever stalls.
    initial begin
        repeat (100000) @(posedge clk);
        $display("[TB] FAIL watchdog: got no finish expected finish within 100000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized frames.
    initial begin
        logic [127:0] img;
        logic [7:0]   nb;
        logic [7:0]   cx;

        reset       = 1'b1;
        rx          = 1'b1;
        mInFrame    = 1'b0;
        mTarget     = '0;
        mLastStrobe = 0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        reset = 1'b0;
        applyIdle(10);

        // Good frame 00..0F, checksum 00, with LED tracking.
        applyStimulus(SYNC, 1'b1);
        checkOutput("ledAfterSync", rx_led, 1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'(i), 1'b1);
        end
        checkOutput("ledInCheck", rx_led, 1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("ledAfterCheck", rx_led, 0);
        checkOutput("loadedAfterFirst", target_loaded, 1);
        checkOutput("targetFirst", target, 128'h000102030405060708090a0b0c0d0e0f);

        // Bad checksum, then a good A0..AF frame.
        sendFrame(128'h000102030405060708090a0b0c0d0e0f, 8'h01);
        checkOutput("targetHeldAfterBadCsum", target, 128'h000102030405060708090a0b0c0d0e0f);
        checkOutput("loadedHeldAfterBadCsum", target_loaded, 1);
        sendFrame(128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf, 8'h00);
        checkOutput("targetA0", target, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf);

        // Short glitch, noise bytes, then a valid frame.
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        applyIdle(3 * C);
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'h00, 1'b1);
        checkOutput("ledAfterNoise", rx_led, 0);
        sendFrame(randImg(), 8'h00);

        // Stop-bit error on data byte 2 with the line held low afterwards.
        applyStimulus(SYNC, 1'b1);
        applyStimulus(8'($urandom_range(0, 255)), 1'b1);
        applyStimulus(8'($urandom_range(0, 255)), 1'b1);
        applyStimulus(8'($urandom_range(0, 255)), 1'b0);
        repeat (3 * C) @(posedge clk);
        #1;
        checkOutput("ledAfterStopErr", rx_led, 0);
        rx = 1'b1;
        applyIdle(2 * C);
        sendFrame(randImg(), 8'h00);

        // Timeout after sync plus 5 bytes.
        applyStimulus(SYNC, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 1'b1);
        end
        applyIdle(LIMIT + 60);
        checkOutput("ledAfterTimeout", rx_led, 0);
        checkOutput("targetAfterTimeout", target, mTarget);

        // Reset in the middle of data byte 7.
        applyStimulus(SYNC, 1'b1);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 1'b1);
        end
        nb = 8'($urandom_range(0, 255));
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (C) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1 rx = nb[i];
            repeat (C) @(posedge clk);
        end
        #1;
        reset    = 1'b1;
        rx       = 1'b1;
        mInFrame = 1'b0;
        mTarget  = '0;
        @(posedge clk);
        #1;
        checkAllZero("midReset");
        reset = 1'b0;
        applyIdle(4 * C);
        sendFrame(randImg(), 8'h00);
        checkOutput("loadedAfterReset", target_loaded, 1);

        // Randomized noise, hashes and occasional checksum corruption.
        for (int k = 0; k < 6; k++) begin
            for (int n = 0; n < int'($urandom_range(0, 2)); n++) begin
                do begin
                    nb = 8'($urandom_range(0, 255));
                end while (nb == SYNC);
                applyStimulus(nb, 1'b1);
            end
            img = randImg();
            cx  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            sendFrame(img, cx);
            checkOutput("randTarget", target, mTarget);
            applyIdle(int'($urandom_range(5, 60)));
        end

        applyIdle(50);
        checkOutput("pendingEvents", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/hash_target_rx.md
Name: hash_target_rx

Overview:
UART 8N1 receiver plus frame parser that loads the 128-bit MD5 target hash from the host PC into the brute-force engine. It is the receive counterpart of the cleartext-reporting usart TX path. The block deserialises bytes on the rx pin and validates a framed 16-byte hash with a checksum. It presents the hash, MSB-first as [0:127], to the search FSM's compare stage.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be at least 8.
SYNC_BYTE, 8'h48, frame start marker ('H').
TIMEOUT_BITS, 40, inter-byte idle limit inside a frame, in bit times.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high.
rx  input  1  asynchronous UART line; idles high.
rx_led  output  1  high while a frame is in progress (frame FSM not in WAIT_SYNC).
target  output  128  loaded hash, bit order [0:127], frame byte 0 at [0:7].
target_valid  output  1  one-cycle pulse when target updates.
target_loaded  output  1  level; set by the first good frame, cleared only by reset.
frame_error  output  1  one-cycle pulse on a bad stop bit, bad checksum or timeout.

Behaviour:
- Reset (sync) values: target=0, target_valid=0, target_loaded=0, frame_error=0, rx_led=0. Both FSMs go to their idle states. The rx synchroniser flops reset to 1.
- Input path: rx passes through a 2-flop synchroniser; all logic uses the second flop, rx_s.
- Bit FSM, with states IDLE, START, DATA, STOP, BREAK:
  - IDLE: rx_s==0 -> START, bit counter cleared.
  - START: after CLKS_PER_BIT/2 cycles, sample rx_s. If 0 -> DATA; if 1 -> IDLE (glitch rejected, no byte, no error).
  - DATA: every CLKS_PER_BIT cycles, sample one bit, LSB first. After 8 bits -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample. If 1 -> internal byte_strobe for 1 cycle, then IDLE. If 0 -> frame_error pulse, frame FSM forced to WAIT_SYNC, then BREAK.
  - BREAK: wait for rx_s==1, then IDLE.
- Frame FSM, with states WAIT_SYNC, LOAD, CHECK, advanced only on byte_strobe:
  - WAIT_SYNC: byte==SYNC_BYTE -> LOAD, idx=0, csum=0. Any other byte is ignored silently.
  - LOAD: buffer[idx*8 +: 8 in [0:127] order] <= byte; csum ^= byte; idx++. After idx reaches 15 -> CHECK.
  - CHECK: if byte==csum, target <= buffer, target_valid=1 and target_loaded=1. Otherwise frame_error=1 and target is unchanged. Then -> WAIT_SYNC.
  - SYNC_BYTE appearing inside LOAD is ordinary data; there is no resync.
- Latency: target and target_valid are registered 1 cycle after the checksum byte's stop-bit sample cycle.
- Timeout: in LOAD/CHECK an idle counter runs. It is cleared on every byte_strobe and whenever the bit FSM is not IDLE. At TIMEOUT_BITS*CLKS_PER_BIT cycles -> frame_error pulse, WAIT_SYNC, counter cleared. It does not run in WAIT_SYNC.
- Simultaneous events: a stop-bit error overrides any frame progress in the same cycle. Exactly one frame_error pulse is issued per failure event.
- target holds its value across failed frames. A new good frame overwrites it and pulses target_valid again.
- Reset mid-byte or mid-frame: the partial byte and buffer are discarded; target returns to 0.
- Counter widths: the bit-timer holds CLKS_PER_BIT-1; the timeout counter holds TIMEOUT_BITS*CLKS_PER_BIT without wrap.

Test Plan:
(All scenarios use CLKS_PER_BIT=16 and TIMEOUT_BITS=40 unless stated.)
1. Good frame: send 0x48, then bytes 0x00..0x0F, then checksum 0x00. Required: target=128'h000102030405060708090a0b0c0d0e0f, a single target_valid pulse 1 cycle after the last stop sample, target_loaded=1. rx_led is high from the sync byte until CHECK completes.
2. Bad checksum: resend the frame from scenario 1 with checksum 0x01. Required: frame_error pulses once, target_valid stays 0, target is unchanged, then a good frame with bytes 0xA0..0xAF and checksum 0x00 loads correctly.
3. Glitch and noise: a 4-cycle low pulse on rx gives no byte and no error. Bytes 0x55 and 0x00 sent before the sync byte are ignored, and the following valid frame loads.
4. Stop-bit error: byte 2 of a frame is sent with stop=0 and the line is then held low for 3 bit times. Required: frame_error pulses once, the FSM returns to WAIT_SYNC, and no byte is taken until rx returns high; a subsequent good frame loads.
5. Timeout: send sync plus 5 bytes, then idle for 640 cycles. Required: frame_error pulses once at 640±1 cycles after the last stop sample, and the frame is discarded.
6. Reset mid-frame: assert reset for 1 cycle during data byte 7. Required: all outputs are 0 on the next cycle, and a following complete good frame loads normally.
